// File: rtl/const_div_seq_if.sv
// const_div_seq_if: dividend request and quotient/remainder response channels.
// master drives in_valid/in_dividend/out_ready; slave drives in_ready/out_*.
`timescale 1ns/1ps
interface const_div_seq_if #(
  parameter int WIDTH = 16,
  parameter int RW    = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quot;
  logic [RW-1:0]    out_rem;

  modport master (
    output in_valid,
    output in_dividend,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_quot,
    input  out_rem
  );

  modport slave (
    input  in_valid,
    input  in_dividend,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_quot,
    output out_rem
  );
endinterface

// File: rtl/const_div_seq.sv
// const_div_seq: sequential divide by constant DIVISOR, CHUNK bits per cycle.
// Ports: clk, rst (sync, active-high), bus (slave handshake), busy.
`timescale 1ns/1ps
module const_div_seq #(
  parameter int WIDTH   = 16,
  parameter int DIVISOR = 11,
  parameter int CHUNK   = 2
) (
  input  logic            clk,
  input  logic            rst,
  const_div_seq_if.slave  bus,
  output logic            busy
);

  localparam int RW    = $clog2(DIVISOR);
  localparam int STEPS = WIDTH / CHUNK;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int TW    = RW + CHUNK;
  localparam int ND    = 2 ** CHUNK;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_opd;
  logic [WIDTH-1:0] r_quot;
  logic [RW-1:0]    r_rem;
  logic [CW-1:0]    r_cnt;

  logic [TW-1:0]    w_t;
  logic [CHUNK-1:0] w_q;
  logic [RW-1:0]    w_rem;
  logic             w_acc;
  logic             w_step;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_busy;

  // k*DIVISOR folded at elaboration; always fits TW since
  // k*DIVISOR < ND*DIVISOR <= 2**TW.
  function automatic logic [TW-1:0] kmul(input int k);
    return TW'(k * DIVISOR);
  endfunction

  assign w_t = {r_rem, r_opd[WIDTH-1 -: CHUNK]};

  // Compare/subtract chain: the largest k with t >= k*DIVISOR
  // wins because later iterations override earlier ones.
  always_comb begin
    w_q   = '0;
    w_rem = w_t[RW-1:0];
    for (int k = 1; k < ND; k++) begin
      if (w_t >= kmul(k)) begin
        w_q   = CHUNK'(k);
        w_rem = RW'(w_t - kmul(k));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    w_acc       = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (bus.in_valid) begin
          w_acc       = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opd  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
    end else if (w_acc) begin
      r_opd  <= bus.in_dividend;
      r_quot <= '0;
      r_rem  <= '0;
      r_cnt  <= CW'(STEPS - 1);
    end else if (w_step) begin
      r_opd  <= r_opd << CHUNK;
      r_quot <= (r_quot << CHUNK) | WIDTH'(w_q);
      r_rem  <= w_rem;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_quot  = r_quot;
  assign bus.out_rem   = r_rem;
  assign busy          = w_busy;

endmodule

// File: tb/tb_const_div_seq.sv
// tb_const_div_seq: directed table, corner sequences, param sweep
// and a throttled residue sweep for const_div_seq.
`timescale 1ns/1ps
module tb_const_div_seq;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic busy8;
  logic busy12;

  always #5 clk = ~clk;

  const_div_seq_if #(.WIDTH(16), .RW(4)) bus ();
  const_div_seq_if #(.WIDTH(8),  .RW(2)) bus8 ();
  const_div_seq_if #(.WIDTH(12), .RW(3)) bus12 ();

  const_div_seq #(.WIDTH(16), .DIVISOR(11), .CHUNK(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  const_div_seq #(.WIDTH(8), .DIVISOR(3), .CHUNK(1)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus8),
    .busy (busy8)
  );

  const_div_seq #(.WIDTH(12), .DIVISOR(7), .CHUNK(3)) dut12 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus12),
    .busy (busy12)
  );

  typedef struct {
    logic [15:0] d;
    logic [15:0] q;
    logic [3:0]  r;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer d, wait for the result with out_ready high, and complete the
  // handshake. lat = edges from the accept edge to first out_valid.
  task automatic xfer(input  logic [15:0] d,
                      output logic [15:0] q,
                      output logic [3:0]  r,
                      output int          lat);
    int n;
    bus.in_dividend = d;
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("xfer_accept_timeout", 0, 1);
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    q = bus.out_quot;
    r = bus.out_rem;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t        tbl[7];
  logic [15:0] q;
  logic [3:0]  r;
  int          lat;
  int          n;
  logic        seen;
  int          exp_q[$];
  int          idx;
  int          got;
  int          cyc;
  int          d;
  logic        acc;
  logic        ret;
  logic [15:0] qs;
  logic [3:0]  rs;
  localparam int N_SWEEP = 2979;

  initial begin
    tbl[0] = '{d: 16'd1000,  q: 16'd90,   r: 4'd10};
    tbl[1] = '{d: 16'd0,     q: 16'd0,    r: 4'd0};
    tbl[2] = '{d: 16'd10,    q: 16'd0,    r: 4'd10};
    tbl[3] = '{d: 16'd11,    q: 16'd1,    r: 4'd0};
    tbl[4] = '{d: 16'd65535, q: 16'd5957, r: 4'd8};
    tbl[5] = '{d: 16'd12345, q: 16'd1122, r: 4'd3};
    tbl[6] = '{d: 16'd43690, q: 16'd3971, r: 4'd9};

    rst = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.out_ready   = 1'b0;
    bus8.in_valid    = 1'b0;
    bus8.in_dividend = '0;
    bus8.out_ready   = 1'b0;
    bus12.in_valid    = 1'b0;
    bus12.in_dividend = '0;
    bus12.out_ready   = 1'b0;
    repeat (3) tick();

    chk("rst_in_ready",  32'(bus.in_ready),  1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_busy",      32'(busy),          0);
    chk("rst_quot",      32'(bus.out_quot),  0);
    chk("rst_rem",       32'(bus.out_rem),   0);
    rst = 1'b0;
    tick();

    // Back-to-back directed vectors. out_valid is seen STEPS=8 edges
    // after the accept edge and in_ready right after the handshake edge.
    for (int i = 0; i < 7; i++) begin
      xfer(tbl[i].d, q, r, lat);
      chk($sformatf("vec%0d_quot", i), 32'(q), 32'(tbl[i].q));
      chk($sformatf("vec%0d_rem", i),  32'(r), 32'(tbl[i].r));
      chk($sformatf("vec%0d_lat", i),  lat, 8);
      chk($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 1);
      chk($sformatf("vec%0d_ov_clr", i),   32'(bus.out_valid), 0);
    end

    // Backpressure: result held while out_ready is low.
    bus.in_dividend = 16'd1000;
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bp_lat", n, 8);
    for (int c = 0; c < 5; c++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_quot",      32'(bus.out_quot),  90);
      chk("bp_rem",       32'(bus.out_rem),   10);
      chk("bp_in_ready",  32'(bus.in_ready),  0);
      if (c == 1) begin
        bus.in_dividend = 16'd77;
        bus.in_valid    = 1'b1;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    chk("bp_quot_end", 32'(bus.out_quot), 90);
    chk("bp_rem_end",  32'(bus.out_rem),  10);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_ov_after", 32'(bus.out_valid), 0);
    chk("bp_ir_after", 32'(bus.in_ready),  1);
    repeat (3) tick();
    chk("bp_no_ghost", 32'(busy), 0);

    // Reset after the third RUN step.
    bus.in_dividend = 16'd1000;
    bus.in_valid    = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("mr_busy_run", 32'(busy), 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_in_ready",  32'(bus.in_ready),  1);
    chk("mr_busy",      32'(busy),          0);
    chk("mr_out_valid", 32'(bus.out_valid), 0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      seen |= bus.out_valid;
      tick();
    end
    chk("mr_no_ov", 32'(seen), 0);
    xfer(16'd65535, q, r, lat);
    chk("mr_next_quot", 32'(q), 5957);
    chk("mr_next_rem",  32'(r), 8);

    // WIDTH=8, DIVISOR=3, CHUNK=1.
    bus8.in_dividend = 8'd200;
    bus8.in_valid    = 1'b1;
    bus8.out_ready   = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    n = 0;
    while (!bus8.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("p8_lat",  n, 8);
    chk("p8_quot", 32'(bus8.out_quot), 66);
    chk("p8_rem",  32'(bus8.out_rem),  2);
    tick();
    chk("p8_in_ready", 32'(bus8.in_ready), 1);

    // WIDTH=12, DIVISOR=7, CHUNK=3.
    bus12.in_dividend = 12'd4095;
    bus12.in_valid    = 1'b1;
    bus12.out_ready   = 1'b1;
    tick();
    bus12.in_valid = 1'b0;
    n = 0;
    while (!bus12.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("p12_lat",  n, 4);
    chk("p12_quot", 32'(bus12.out_quot), 585);
    chk("p12_rem",  32'(bus12.out_rem),  0);
    tick();
    chk("p12_in_ready", 32'(bus12.in_ready), 1);

    // Throttled sweep: stride 22 plus offset hits every residue
    // across the whole dividend range.
    idx = 0;
    got = 0;
    cyc = 0;
    bus.in_valid = 1'b0;
    while (got < N_SWEEP && cyc < 60000) begin
      if (!bus.in_valid && idx < N_SWEEP && $urandom_range(0, 3) != 0) begin
        bus.in_dividend = 16'(idx * 22 + idx % 22);
        bus.in_valid    = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      acc = bus.in_valid && bus.in_ready;
      ret = bus.out_valid && bus.out_ready;
      qs  = bus.out_quot;
      rs  = bus.out_rem;
      tick();
      cyc++;
      if (acc) begin
        exp_q.push_back(int'(bus.in_dividend));
        idx++;
        bus.in_valid = 1'b0;
      end
      if (ret) begin
        got++;
        if (exp_q.size() == 0) begin
          chk("sweep_spurious", 1, 0);
        end else begin
          d = exp_q.pop_front();
          chk($sformatf("sweep_d%0d", d),
              {qs, 12'h0, rs},
              {16'(d / 11), 16'(d % 11)});
        end
      end
    end
    chk("sweep_count", got, N_SWEEP);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
